mem_arbiter: RTL and testbench

Arbitrates the single-port program/data memory of the 8-bit CPU between two requesters: the core (instruction fetch and LOAD/store traffic driven by the control unit's `mem_sel`/`mem_we`) and a debug/loader port used to download programs and inspect memory. Arbitration uses fixed priority to the core, with a starvation guard that guarantees the debug port progress. An optional lock holds the debug port's ownership across multi-cycle bursts. The block sits between the core datapath, the debug port and the memory macro.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core, debug and memory-macro signals of the memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              core_req;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_wdata;
    logic              core_gnt;
    logic              core_rvalid;
    logic [DATA_W-1:0] core_rdata;
    logic              dbg_req;
    logic              dbg_we;
    logic              dbg_lock;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: core-priority memory arbiter with debug starvation guard; MEM_ARB_LOCK_EN adds debug burst lock
module mem_arbiter #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]  arb_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, CORE = 2'b01, DBG = 2'b10, LOCKED = 2'b11} state_t;

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt;
    logic              starve_hit, core_win, dbg_win;
    logic              rv_core, rv_dbg;
    logic [DATA_W-1:0] core_hold, dbg_hold;
`ifdef MEM_ARB_LOCK_EN
    logic [7:0]        lock_cnt;
    logic              lock_blk, lock_exit, lock_force;
`endif

    // winner selection, memory mux, read-return steering and next state
    always_comb begin
        starve_hit      = bus.dbg_req && starve_cnt == 4'(STARVE_LIMIT);
        dbg_win         = state == LOCKED ? bus.dbg_req : bus.dbg_req && (starve_hit || !bus.core_req);
        core_win        = state != LOCKED && bus.core_req && !dbg_win;
        bus.core_gnt    = !reset && core_win;
        bus.dbg_gnt     = !reset && dbg_win;
        bus.mem_en      = bus.core_gnt || bus.dbg_gnt;
        bus.mem_we      = bus.dbg_gnt ? bus.dbg_we : bus.core_gnt && bus.core_we;
        bus.mem_addr    = bus.dbg_gnt ? bus.dbg_addr : bus.core_gnt ? bus.core_addr : '0;
        bus.mem_wdata   = bus.dbg_gnt ? bus.dbg_wdata : bus.core_gnt ? bus.core_wdata : '0;
        bus.core_rvalid = rv_core && !reset;
        bus.dbg_rvalid  = rv_dbg && !reset;
        bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : core_hold;
        bus.dbg_rdata   = bus.dbg_rvalid ? bus.mem_rdata : dbg_hold;
        state_nxt       = bus.core_gnt ? CORE : bus.dbg_gnt ? DBG : IDLE;
`ifdef MEM_ARB_LOCK_EN
        lock_exit       = !bus.dbg_lock || lock_cnt == 8'(LOCK_MAX - 1);
        lock_force      = state == LOCKED && bus.dbg_lock && lock_cnt == 8'(LOCK_MAX - 1);
        state_nxt       = (state == LOCKED && !lock_exit) ||
                          (state != LOCKED && bus.dbg_gnt && bus.dbg_lock && !lock_blk) ? LOCKED : state_nxt;
`endif
        arb_state       = state;
    end

    // state, starvation counter and registered read-return ownership
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            rv_core    <= 1'b0;
            rv_dbg     <= 1'b0;
            core_hold  <= '0;
            dbg_hold   <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= (!bus.dbg_req || bus.dbg_gnt) ? 4'd0 : starve_hit ? starve_cnt : starve_cnt + 4'd1;
            rv_core    <= bus.core_gnt && !bus.core_we;
            rv_dbg     <= bus.dbg_gnt && !bus.dbg_we;
            if (rv_core) core_hold <= bus.mem_rdata;
            if (rv_dbg) dbg_hold <= bus.mem_rdata;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    // lock duration counter and re-entry block after a forced release
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt <= '0;
            lock_blk <= 1'b0;
        end else begin
            lock_cnt <= (state == LOCKED && !lock_exit) ? lock_cnt + 8'd1 : 8'd0;
            lock_blk <= lock_force ? 1'b1 : !bus.dbg_lock ? 1'b0 : lock_blk;
        end
    end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a cycle-level reference model of the memory arbiter
module tb_mem_arbiter;
    localparam int AW = 4, DW = 8, SL = 4, LM = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] arb_state;
    int         checks = 0, errors = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [16];
    logic [7:0] shadow [16];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
        mem[3] = 8'h6F;
        for (int i = 0; i < 16; i++) shadow[i] = mem[i];
    end

    // memory macro: synchronous read, one cycle latency
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: who should win, what each side should see
    int         m_starve = 0, m_last = 0, m_pend = 0, m_lockc = 0;
    bit         m_locked = 0, m_blocked = 0;
    logic [7:0] m_pdata = 0, m_chold = 0, m_dhold = 0;
    bit         eg_c, eg_d, e_crv, e_drv;

    always @(negedge clk) begin
        eg_d  = reset ? 0 : m_locked ? bus.dbg_req : bus.dbg_req && (m_starve >= SL || !bus.core_req);
        eg_c  = !reset && !m_locked && bus.core_req && !eg_d;
        e_crv = !reset && m_pend == 1;
        e_drv = !reset && m_pend == 2;
        chk("core_gnt", bus.core_gnt, eg_c);
        chk("dbg_gnt", bus.dbg_gnt, eg_d);
        chk("mem_en", bus.mem_en, eg_c | eg_d);
        chk("mem_we", bus.mem_we, eg_d ? bus.dbg_we : eg_c & bus.core_we);
        chk("mem_addr", bus.mem_addr, eg_d ? bus.dbg_addr : eg_c ? bus.core_addr : 0);
        chk("mem_wdata", bus.mem_wdata, eg_d ? bus.dbg_wdata : eg_c ? bus.core_wdata : 0);
        chk("core_rvalid", bus.core_rvalid, e_crv);
        chk("dbg_rvalid", bus.dbg_rvalid, e_drv);
        chk("core_rdata", bus.core_rdata, e_crv ? m_pdata : m_chold);
        chk("dbg_rdata", bus.dbg_rdata, e_drv ? m_pdata : m_dhold);
        chk("arb_state", arb_state, m_locked ? 3 : m_last);
    end

    always @(posedge clk) begin
        if (reset) begin
            m_starve = 0; m_last = 0; m_pend = 0; m_lockc = 0;
            m_locked = 0; m_blocked = 0; m_pdata = 0; m_chold = 0; m_dhold = 0;
        end else begin
            if (e_crv) m_chold = m_pdata;
            if (e_drv) m_dhold = m_pdata;
            m_pend  = (eg_c && !bus.core_we) ? 1 : (eg_d && !bus.dbg_we) ? 2 : 0;
            m_pdata = eg_c ? shadow[bus.core_addr] : shadow[bus.dbg_addr];
            if (eg_c && bus.core_we) shadow[bus.core_addr] = bus.core_wdata;
            if (eg_d && bus.dbg_we) shadow[bus.dbg_addr] = bus.dbg_wdata;
            m_starve = (!bus.dbg_req || eg_d) ? 0 : (m_starve < SL ? m_starve + 1 : SL);
            m_last   = eg_c ? 1 : eg_d ? 2 : 0;
`ifdef MEM_ARB_LOCK_EN
            if (!bus.dbg_lock) m_blocked = 0;
            if (m_locked) begin
                m_lockc++;
                if (!bus.dbg_lock || m_lockc == LM) begin
                    m_blocked = bus.dbg_lock;
                    m_locked  = 0;
                    m_lockc   = 0;
                end
            end else if (eg_d && bus.dbg_lock && !m_blocked) m_locked = 1;
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] gc, gd;
    int         nlock, first_core;

    initial begin
        bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_lock = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
        tick(); tick();
        reset = 0;
        // core read of address 3
        tick();
        bus.core_req = 1; bus.core_addr = 3;
        @(negedge clk);
        chk("t1_gnt", {bus.core_gnt, bus.mem_en, bus.mem_addr}, {2'b11, 4'd3});
        tick();
        bus.core_req = 0;
        @(negedge clk);
        chk("t1_rdata", {bus.core_rvalid, bus.core_rdata, bus.dbg_rvalid}, {1'b1, 8'h6F, 1'b0});
        chk("t1_state", arb_state, 2'b01);
        // starvation guard with both sides requesting continuously
        tick();
        bus.core_req = 1; bus.core_addr = 5; bus.dbg_req = 1; bus.dbg_addr = 6;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            gc[c] = bus.core_gnt;
            gd[c] = bus.dbg_gnt;
            tick();
        end
        chk("t2_core_pattern", gc, 6'b101111);
        chk("t2_dbg_pattern", gd, 6'b010000);
        // debug writes, then core reads back
        bus.core_req = 0;
        bus.dbg_we = 1; bus.dbg_addr = 0; bus.dbg_wdata = 8'h08;
        @(negedge clk);
        chk("t3_w0", {bus.dbg_gnt, bus.mem_we, bus.mem_wdata}, {2'b11, 8'h08});
        tick();
        bus.dbg_addr = 1; bus.dbg_wdata = 8'h14;
        @(negedge clk);
        chk("t3_w1", {bus.dbg_gnt, bus.mem_we, bus.mem_addr}, {2'b11, 4'd1});
        tick();
        bus.dbg_req = 0; bus.dbg_we = 0;
        bus.core_req = 1; bus.core_addr = 1;
        @(negedge clk);
        chk("t3_cgnt", bus.core_gnt, 1'b1);
        tick();
        bus.core_req = 0;
        @(negedge clk);
        chk("t3_rdata", {bus.core_rvalid, bus.core_rdata}, {1'b1, 8'h14});
`ifdef MEM_ARB_LOCK_EN
        // locked debug burst blocks the core until dbg_lock drops
        tick();
        bus.dbg_req = 1; bus.dbg_lock = 1; bus.dbg_addr = 0;
        @(negedge clk);
        chk("t4_first", bus.dbg_gnt, 1'b1);
        tick();
        bus.core_req = 1; bus.core_addr = 2; bus.dbg_addr = 1;
        @(negedge clk);
        chk("t4_lock1", {arb_state, bus.core_gnt, bus.dbg_gnt}, 4'b1101);
        tick();
        bus.dbg_addr = 2;
        @(negedge clk);
        chk("t4_lock2", {arb_state, bus.core_gnt, bus.dbg_gnt}, 4'b1101);
        tick();
        bus.dbg_lock = 0; bus.dbg_req = 0;
        @(negedge clk);
        chk("t4_release_cycle", {arb_state, bus.core_gnt}, 3'b110);
        tick();
        @(negedge clk);
        chk("t4_core_after", bus.core_gnt, 1'b1);
        tick();
        bus.core_req = 0;
        // forced release after LOCK_MAX cycles, no re-entry while dbg_lock stays high
        tick();
        bus.dbg_req = 1; bus.dbg_lock = 1; bus.dbg_addr = 4;
        tick();
        bus.core_req = 1; bus.core_addr = 7;
        nlock = 0; first_core = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (arb_state == 2'b11) nlock++;
            if (bus.core_gnt && first_core == 0) first_core = c;
            tick();
        end
        chk("t5_locked_cycles", nlock, 8);
        chk("t5_first_core", first_core, 9);
        bus.core_req = 0; bus.dbg_req = 0; bus.dbg_lock = 0;
        tick();
`endif
        // reset the cycle after a debug read grant
        tick();
        bus.dbg_req = 1; bus.dbg_addr = 1;
        @(negedge clk);
        chk("t6_grant", bus.dbg_gnt, 1'b1);
        tick();
        reset = 1; bus.core_req = 1;
        @(negedge clk);
        chk("t6_in_reset", {bus.dbg_rvalid, bus.core_gnt, bus.dbg_gnt, bus.mem_en}, 4'b0000);
        tick();
        reset = 0; bus.core_req = 0; bus.dbg_req = 0;
        @(negedge clk);
        chk("t6_after", {arb_state, bus.dbg_rvalid, bus.core_rvalid}, 4'b0000);
        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
